frame_loader: RTL and testbench
===============================

Name: frame_loader

Overview:
- Parametrised frame-buffer-to-display streamer: reads one RAM word per display row and emits every pixel of the frame as an (x, y, color) stream for the VGA draw path.
- Generalises the single-bit loader to:
  - multi-bit pixels;
  - configurable resolution and RAM read latency;
  - start/busy/done control;
  - valid/ready back-pressure;
  - optional horizontal mirroring.
- Sits between the row-organised frame RAM and the pixel-write port of the VGA framebuffer.

Parameters:
- H_RES, 640, pixels per row; RAM word width is H_RES*BPP.
- V_RES, 480, rows per frame; also the RAM depth.
- BPP, 1, bits per pixel.
- RAM_LAT, 1, RAM read latency in cycles from read_addr to valid q (1..4).
- ADDR_W, 9, RAM address width; must satisfy 2^ADDR_W >= V_RES.
- COORD_W, 11, width of the pix_x/pix_y outputs.

Ports:
- CLOCK_50  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to load a frame; sampled only in IDLE.
- abort  in  1  terminates the current frame; takes priority over all other inputs except reset.
- mirror  in  1  captured on accepted start; 1 = emit row right-to-left.
- busy  out  1  high from the cycle after an accepted start until the cycle done is asserted.
- done  out  1  one-cycle pulse after the last pixel is accepted.
- read_addr  out  ADDR_W  RAM row address.
- q  in  H_RES*BPP  RAM read data; pixel x occupies bits [x*BPP +: BPP].
- pix_x  out  COORD_W  column of the current pixel, zero-extended.
- pix_y  out  COORD_W  row of the current pixel, zero-extended.
- pix_color  out  BPP  pixel value.
- pix_valid  out  1  pixel outputs are valid.
- pix_ready  in  1  consumer accepts the pixel when pix_valid && pix_ready.

Behaviour:
- Reset: the following are all 0 and the FSM is in IDLE:
  - busy, done, pix_valid;
  - read_addr, pix_x, pix_y, pix_color;
  - all internal counters and the row buffer.
- FSM states: IDLE, FETCH, LATCH, STREAM, DONE.
- IDLE -> FETCH on start:
  - capture mirror;
  - set row counter to 0 and read_addr = 0;
  - set busy.
- FETCH: hold read_addr = row for RAM_LAT cycles (wait counter), then go to LATCH.
- LATCH: register q into the row buffer (one cycle), then go to STREAM.
  - Column counter initialises to 0.
  - Emitted x = col when mirror = 0; x = H_RES-1-col when mirror = 1.
- STREAM:
  - pix_valid = 1.
  - pix_x, pix_y and pix_color are registered and stay stable while pix_valid && !pix_ready.
  - On each handshake the column advances by 1.
  - On a handshake at col = H_RES-1:
    - if row = V_RES-1, go to DONE;
    - otherwise row increments, read_addr = row+1, go to FETCH.
- DONE: done = 1 and busy = 0 for exactly one cycle, then IDLE.
- Throughput:
  - with pix_ready held high, one pixel per cycle within a row;
  - each row costs RAM_LAT+1 bubble cycles (FETCH + LATCH);
  - a full frame takes V_RES*(H_RES+RAM_LAT+1)+1 cycles from start to done.
- Coverage: every (x, y) with 0<=x<H_RES and 0<=y<V_RES is emitted exactly once, row-major; no skipped final row or column.
- abort: in any non-IDLE state, go to IDLE on the next edge.
  - pix_valid, busy and done go to 0.
  - No done pulse is produced.
  - A pixel presented in the abort cycle is not considered accepted.
- start:
  - ignored while busy or in DONE;
  - start and abort asserted together in IDLE: abort wins and start is ignored.
- mirror changes after start have no effect until the next frame.
- Counters never wrap past H_RES-1 or V_RES-1; the row counter resets to 0 only on a new start.
- Asynchronous reset mid-frame: all outputs go to reset values immediately, regardless of the clock.

Test Plan:
- Params H_RES=8, V_RES=4, BPP=2, RAM_LAT=1; RAM row r holds pixel x = (r+x)%4; pix_ready=1; pulse start → 32 pixels in row-major order, color = (y+x)%4, done pulse at cycle 4*(8+2)+1 = 41 after start, busy low afterwards.
- Same setup with mirror=1 at start → row 0 emits x=7..0 with colors 3,2,1,0,3,2,1,0; all 32 coordinates emitted exactly once.
- Toggle pix_ready pseudo-randomly at 50% → outputs stable while stalled, no pixel duplicated or lost, 32 handshakes total, then done.
- RAM_LAT=3 model → read_addr held 3 cycles per row, colors still correct, done at cycle 4*(8+4)+1 = 49.
- abort asserted on the 13th pixel (row 1, x=4) → busy and pix_valid low next cycle, no done; a new start restarts from (0,0).
- Assert start while busy; assert reset_n=0 mid-row → start ignored, no restart; reset gives all outputs 0 asynchronously and state IDLE.

Source files
------------

// File: rtl/frame_loader_if.sv
// frame_loader_if: frame RAM read port plus the (x, y, color) pixel stream
// toward the VGA framebuffer write port.
interface frame_loader_if #(
    parameter int H_RES   = 640,
    parameter int BPP     = 1,
    parameter int ADDR_W  = 9,
    parameter int COORD_W = 11
);
    logic [ADDR_W-1:0]    read_addr;
    logic [H_RES*BPP-1:0] q;
    logic [COORD_W-1:0]   pix_x;
    logic [COORD_W-1:0]   pix_y;
    logic [BPP-1:0]       pix_color;
    logic                 pix_valid;
    logic                 pix_ready;
    modport master (output read_addr, pix_x, pix_y, pix_color, pix_valid, input q, pix_ready);
    modport slave  (input read_addr, pix_x, pix_y, pix_color, pix_valid, output q, pix_ready);
endinterface

// File: rtl/frame_loader.sv
// frame_loader: streams a row-organised frame RAM out as (x, y, color) pixels,
// one RAM word per row, with back-pressure, abort and optional mirroring.
module frame_loader #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int BPP     = 1,
    parameter int RAM_LAT = 1,
    parameter int ADDR_W  = 9,
    parameter int COORD_W = 11
) (
    input  logic           CLOCK_50,
    input  logic           reset_n,
    input  logic           start,
    input  logic           abort,
    input  logic           mirror,
    output logic           busy,
    output logic           done,
    frame_loader_if.master px
);
    localparam int CW = H_RES > 1 ? $clog2(H_RES) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, STREAM, DONE} state_t;

    state_t               state_q, state_d;
    logic                 mirror_q, mirror_d;
    logic [ADDR_W-1:0]    row_q, row_d;
    logic [CW-1:0]        col_q, col_d;
    logic [1:0]           lat_cnt_q, lat_cnt_d;
    logic [H_RES*BPP-1:0] buf_q, buf_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 valid_q, valid_d;
    logic [CW-1:0]        x_q, x_d;
    logic [BPP-1:0]       color_q, color_d;
    logic [CW-1:0]        first_x, next_x;

    function automatic logic [CW-1:0] emit_x(input logic m, input logic [CW-1:0] c);
        return m ? CW'(H_RES - 1) - c : c;
    endfunction

    assign first_x = emit_x(mirror_q, '0);
    assign next_x  = emit_x(mirror_q, col_q + 1'b1);

    always_comb begin
        state_d   = state_q;
        mirror_d  = mirror_q;
        row_d     = row_q;
        col_d     = col_q;
        lat_cnt_d = lat_cnt_q;
        buf_d     = buf_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        x_d       = x_q;
        color_d   = color_q;
        if (abort) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d   = FETCH;
                    mirror_d  = mirror;
                    row_d     = '0;
                    lat_cnt_d = '0;
                    busy_d    = 1'b1;
                end
                FETCH: begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                    if (lat_cnt_q == 2'(RAM_LAT - 1)) state_d = LATCH;
                end
                LATCH: begin
                    buf_d   = px.q;
                    col_d   = '0;
                    x_d     = first_x;
                    color_d = px.q[first_x*BPP +: BPP];
                    valid_d = 1'b1;
                    state_d = STREAM;
                end
                STREAM: if (px.pix_ready) begin
                    if (col_q == CW'(H_RES - 1)) begin
                        valid_d = 1'b0;
                        if (row_q == ADDR_W'(V_RES - 1)) begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            row_d     = row_q + 1'b1;
                            lat_cnt_d = '0;
                            state_d   = FETCH;
                        end
                    end else begin
                        col_d   = col_q + 1'b1;
                        x_d     = next_x;
                        color_d = buf_q[next_x*BPP +: BPP];
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            mirror_q  <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            lat_cnt_q <= '0;
            buf_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            x_q       <= '0;
            color_q   <= '0;
        end else begin
            state_q   <= state_d;
            mirror_q  <= mirror_d;
            row_q     <= row_d;
            col_q     <= col_d;
            lat_cnt_q <= lat_cnt_d;
            buf_q     <= buf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            x_q       <= x_d;
            color_q   <= color_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign px.read_addr = row_q;
    assign px.pix_x     = COORD_W'(x_q);
    assign px.pix_y     = COORD_W'(row_q);
    assign px.pix_color = color_q;
    assign px.pix_valid = valid_q;
endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader: frame scenarios from a vector table checked against a pixel
// scoreboard, plus hand-written abort, start/abort and async reset sequences.
module tb_frame_loader;
    localparam int H = 8, V = 4, B = 2;

    logic clk = 0, reset_n = 1, start1 = 0, start3 = 0, abort = 0, mirror = 0;
    logic busy1, done1, busy3, done3;
    logic [15:0] p3a, p3b;
    int tests = 0, failed = 0;

    typedef struct {int x; int y; int c;} pix_t;
    typedef struct {bit lat3; bit mir; bit rnd; int exp_n;} vec_t;
    pix_t exp_q[$];

    always #5 clk = ~clk;

    frame_loader_if #(.H_RES(H), .BPP(B), .ADDR_W(2), .COORD_W(11)) if1 ();
    frame_loader_if #(.H_RES(H), .BPP(B), .ADDR_W(2), .COORD_W(11)) if3 ();

    frame_loader #(.H_RES(H), .V_RES(V), .BPP(B), .RAM_LAT(1), .ADDR_W(2), .COORD_W(11)) u1 (
        .CLOCK_50(clk), .reset_n(reset_n), .start(start1), .abort(abort), .mirror(mirror),
        .busy(busy1), .done(done1), .px(if1));
    frame_loader #(.H_RES(H), .V_RES(V), .BPP(B), .RAM_LAT(3), .ADDR_W(2), .COORD_W(11)) u3 (
        .CLOCK_50(clk), .reset_n(reset_n), .start(start3), .abort(abort), .mirror(mirror),
        .busy(busy3), .done(done3), .px(if3));

    function automatic logic [15:0] row_word(input logic [1:0] r);
        logic [15:0] w;
        for (int x = 0; x < H; x++) w[x*2 +: 2] = 2'((int'(r) + x) % 4);
        return w;
    endfunction

    always @(posedge clk) if1.q <= row_word(if1.read_addr);
    always @(posedge clk) begin
        p3a   <= row_word(if3.read_addr);
        p3b   <= p3a;
        if3.q <= p3b;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v);
        int n;
        pix_t p;
        logic rdy, vld, dn, bsy;
        int px_x, px_y, px_c;
        dn = 0;
        bsy = 0;
        exp_q.delete();
        for (int y = 0; y < V; y++)
            for (int c = 0; c < H; c++) begin
                p.x = v.mir ? H - 1 - c : c;
                p.y = y;
                p.c = (y + p.x) % 4;
                exp_q.push_back(p);
            end
        @(negedge clk);
        mirror = v.mir;
        if (v.lat3) start3 = 1; else start1 = 1;
        @(posedge clk);
        n = 1;
        while (n < 400) begin
            @(negedge clk);
            if (v.lat3) start3 = (n == 15); else start1 = (n == 15);
            if (n == 1) mirror = !v.mir;
            rdy = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if1.pix_ready = rdy;
            if3.pix_ready = rdy;
            vld  = v.lat3 ? if3.pix_valid : if1.pix_valid;
            dn   = v.lat3 ? done3 : done1;
            bsy  = v.lat3 ? busy3 : busy1;
            px_x = int'(v.lat3 ? if3.pix_x : if1.pix_x);
            px_y = int'(v.lat3 ? if3.pix_y : if1.pix_y);
            px_c = int'(v.lat3 ? if3.pix_color : if1.pix_color);
            if (n == 1) chk("busy_after_start", int'(bsy), 1);
            if (dn) break;
            if (vld) begin
                if (exp_q.size() == 0) chk("extra_pixel", 1, 0);
                else begin
                    chk("pix_x", px_x, exp_q[0].x);
                    chk("pix_y", px_y, exp_q[0].y);
                    chk("pix_color", px_c, exp_q[0].c);
                    if (rdy) void'(exp_q.pop_front());
                end
            end
            @(posedge clk);
            n++;
        end
        start1 = 0;
        start3 = 0;
        chk("done_seen", int'(dn), 1);
        if (v.exp_n > 0) chk("done_cycle", n, v.exp_n);
        chk("busy_in_done", int'(bsy), 0);
        chk("pixels_left", exp_q.size(), 0);
        @(negedge clk);
        chk("done_one_cycle", int'(v.lat3 ? done3 : done1), 0);
        chk("busy_after_done", int'(v.lat3 ? busy3 : busy1), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy1), 0);
        chk({tag, "_done"}, int'(done1), 0);
        chk({tag, "_valid"}, int'(if1.pix_valid), 0);
        chk({tag, "_addr"}, int'(if1.read_addr), 0);
        chk({tag, "_x"}, int'(if1.pix_x), 0);
        chk({tag, "_y"}, int'(if1.pix_y), 0);
        chk({tag, "_color"}, int'(if1.pix_color), 0);
    endtask

    initial begin
        vec_t tbl[5];
        int k;
        logic seen;
        tbl[0] = '{lat3: 0, mir: 0, rnd: 0, exp_n: 41};
        tbl[1] = '{lat3: 0, mir: 1, rnd: 0, exp_n: 41};
        tbl[2] = '{lat3: 0, mir: 0, rnd: 1, exp_n: 0};
        tbl[3] = '{lat3: 1, mir: 0, rnd: 0, exp_n: 49};
        tbl[4] = '{lat3: 1, mir: 1, rnd: 1, exp_n: 0};
        if1.pix_ready = 1;
        if3.pix_ready = 1;
        #1 reset_n = 0;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        reset_n = 1;
        for (int i = 0; i < 5; i++) run_frame(tbl[i]);

        if1.pix_ready = 1;
        @(negedge clk);
        mirror = 0;
        start1 = 1;
        @(posedge clk);
        @(negedge clk);
        start1 = 0;
        k = 0;
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (if1.pix_valid && k == 12) begin
                chk("abort_px_x", int'(if1.pix_x), 4);
                chk("abort_px_y", int'(if1.pix_y), 1);
                abort = 1;
                @(posedge clk);
                @(negedge clk);
                abort = 0;
                chk("abort_busy", int'(busy1), 0);
                chk("abort_valid", int'(if1.pix_valid), 0);
                chk("abort_done", int'(done1), 0);
                seen = 1;
            end else begin
                if (if1.pix_valid) k++;
                @(negedge clk);
            end
        end
        chk("abort_reached", int'(seen), 1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | done1 | busy1;
        end
        chk("no_done_after_abort", int'(seen), 0);

        start1 = 1;
        abort = 1;
        @(posedge clk);
        @(negedge clk);
        start1 = 0;
        abort = 0;
        chk("start_abort_idle_busy", int'(busy1), 0);
        @(negedge clk);
        chk("start_abort_idle_valid", int'(if1.pix_valid), 0);
        run_frame(tbl[0]);

        @(negedge clk);
        start1 = 1;
        @(posedge clk);
        @(negedge clk);
        start1 = 0;
        repeat (14) @(negedge clk);
        chk("pre_reset_busy", int'(busy1), 1);
        chk("pre_reset_addr", int'(if1.read_addr), 1);
        #2 reset_n = 0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        reset_n = 1;
        repeat (3) @(negedge clk);
        chk("post_reset_busy", int'(busy1), 0);
        chk("post_reset_valid", int'(if1.pix_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
